// File: rtl/cpu_controller.sv
// Multicycle CPU control unit: fetches a 16-bit instruction into the IR, then
// sequences the datapath through a Moore FSM, one datapath step per state.
module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mdata,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        muxccontrol,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [1:0]  mem_cmd,
    output logic        addr_sel,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDPC,
        S_DECODE,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_ALU,
        S_WBC,
        S_ADDR,
        S_LADDR,
        S_MRD,
        S_MWB,
        S_SGETB,
        S_SMOV,
        S_SWR,
        S_HALT
    } state_t;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_C      = 2'b00;
    localparam logic [1:0] VSEL_IMM8   = 2'b10;
    localparam logic [1:0] VSEL_MDATA  = 2'b11;

    // {opcode, op} keys of the supported instructions
    localparam logic [4:0] K_MOV_IMM = 5'b11010;
    localparam logic [4:0] K_MOV_REG = 5'b11000;
    localparam logic [4:0] K_MVN     = 5'b10111;
    localparam logic [4:0] K_ADD     = 5'b10100;
    localparam logic [4:0] K_CMP     = 5'b10101;
    localparam logic [4:0] K_AND     = 5'b10110;
    localparam logic [4:0] K_LDR     = 5'b01100;
    localparam logic [4:0] K_STR     = 5'b10000;
    localparam logic [4:0] K_HALT    = 5'b11100;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] ir_reg;

    logic [4:0]  op_key;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic        is_ldr;
    logic        is_str;
    logic        is_mov_reg;
    logic        is_cmp;

    assign op_key = ir_reg[15:11];
    assign op     = ir_reg[12:11];
    assign rn     = ir_reg[10:8];
    assign rd     = ir_reg[7:5];
    assign sh     = ir_reg[4:3];
    assign rm     = ir_reg[2:0];

    assign is_ldr     = (op_key == K_LDR);
    assign is_str     = (op_key == K_STR);
    assign is_mov_reg = (op_key == K_MOV_REG);
    assign is_cmp     = (op_key == K_CMP);

    // The A/B registers always load from the register file in this design
    assign muxccontrol = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sext
            if (gi < 8) begin : g_imm8_lo
                assign sximm8[gi] = ir_reg[gi];
            end else begin : g_imm8_hi
                assign sximm8[gi] = ir_reg[7];
            end
            if (gi < 5) begin : g_imm5_lo
                assign sximm5[gi] = ir_reg[gi];
            end else begin : g_imm5_hi
                assign sximm5[gi] = ir_reg[4];
            end
        end
    endgenerate

    // IR captures memory data on the last cycle of the fetch read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_RST;
            ir_reg    <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IF2) begin
                ir_reg <= mdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        readnum    = 3'd0;
        writenum   = 3'd0;
        vsel       = VSEL_C;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shift      = 2'b00;
        ALUop      = 2'b00;
        mem_cmd    = MEM_NONE;
        addr_sel   = 1'b0;
        load_pc    = 1'b0;
        reset_pc   = 1'b0;
        load_addr  = 1'b0;
        halted     = 1'b0;

        case (state_reg)
            S_RST: begin
                reset_pc   = 1'b1;
                load_pc    = 1'b1;
                state_next = S_IF1;
            end
            S_IF1: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                state_next = S_IF2;
            end
            S_IF2: begin
                addr_sel   = 1'b1;
                mem_cmd    = MEM_READ;
                state_next = S_UPDPC;
            end
            S_UPDPC: begin
                load_pc    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op_key)
                    K_MOV_IMM:              state_next = S_WIMM;
                    K_MOV_REG, K_MVN:       state_next = S_GETB;
                    K_ADD, K_CMP, K_AND:    state_next = S_GETA;
                    K_LDR, K_STR:           state_next = S_GETA;
                    K_HALT:                 state_next = S_HALT;
                    default:                state_next = S_IF1;
                endcase
            end
            S_WIMM: begin
                vsel       = VSEL_IMM8;
                writenum   = rn;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_GETA: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = (is_ldr || is_str) ? S_ADDR : S_GETB;
            end
            S_GETB: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = S_ALU;
            end
            S_ALU: begin
                // MOV reg passes the shifted B through as 0 + B
                shift = sh;
                ALUop = is_mov_reg ? 2'b00 : op;
                asel  = is_mov_reg;
                if (is_cmp) begin
                    loads      = 1'b1;
                    state_next = S_IF1;
                end else begin
                    loadc      = 1'b1;
                    state_next = S_WBC;
                end
            end
            S_WBC: begin
                vsel       = VSEL_C;
                writenum   = rd;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_LADDR;
            end
            S_LADDR: begin
                load_addr  = 1'b1;
                state_next = is_ldr ? S_MRD : S_SGETB;
            end
            S_MRD: begin
                mem_cmd    = MEM_READ;
                state_next = S_MWB;
            end
            S_MWB: begin
                mem_cmd    = MEM_READ;
                vsel       = VSEL_MDATA;
                writenum   = rd;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_SGETB: begin
                readnum    = rd;
                loadb      = 1'b1;
                state_next = S_SMOV;
            end
            S_SMOV: begin
                // Route the store data (B) through the ALU into C
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_SWR;
            end
            S_SWR: begin
                mem_cmd    = MEM_WRITE;
                state_next = S_IF1;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: begin
                state_next = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus queues expected per-cycle
// control vectors; a monitor pops and compares them against the DUT outputs.
module tb_cpu_controller;

    logic        clk;
    logic        reset_n;
    logic [15:0] mdata;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        muxccontrol;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [1:0]  mem_cmd;
    logic        addr_sel;
    logic        load_pc;
    logic        reset_pc;
    logic        load_addr;
    logic        halted;

    cpu_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mdata       (mdata),
        .readnum     (readnum),
        .writenum    (writenum),
        .vsel        (vsel),
        .write       (write),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .asel        (asel),
        .bsel        (bsel),
        .muxccontrol (muxccontrol),
        .shift       (shift),
        .ALUop       (alu_op),
        .sximm8      (sximm8),
        .sximm5      (sximm5),
        .mem_cmd     (mem_cmd),
        .addr_sel    (addr_sel),
        .load_pc     (load_pc),
        .reset_pc    (reset_pc),
        .load_addr   (load_addr),
        .halted      (halted)
    );

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       muxccontrol;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic [1:0] mem_cmd;
        logic       addr_sel;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       halted;
    } ctrl_t;

    typedef struct {
        string       name;
        ctrl_t       exp;
        bit          chk_imm;
        logic [15:0] imm8;
        logic [15:0] imm5;
    } sb_t;

    sb_t  sbq[$];
    int   n_cmp;
    int   n_bad;
    event probe;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Monitor: one expected entry per sample point (negedge, or an explicit probe)
    initial begin
        sb_t   e;
        ctrl_t act;
        forever begin
            @(negedge clk or probe);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                act = '{readnum, writenum, vsel, write, loada, loadb, loadc, loads,
                        asel, bsel, muxccontrol, shift, alu_op, mem_cmd,
                        addr_sel, load_pc, reset_pc, load_addr, halted};
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: ctrl actual=%h required=%h", e.name, act, e.exp);
                end else if (e.chk_imm && (sximm8 !== e.imm8 || sximm5 !== e.imm5)) begin
                    n_bad++;
                    $display("FAIL %s: sximm8/sximm5 actual=%h/%h required=%h/%h",
                             e.name, sximm8, sximm5, e.imm8, e.imm5);
                end else begin
                    $display("%0t check %s ok", $time, e.name);
                end
            end
        end
    end

    task automatic push(input string n, input ctrl_t c);
        sb_t e;
        e.name = n; e.exp = c; e.chk_imm = 1'b0; e.imm8 = '0; e.imm5 = '0;
        sbq.push_back(e);
    endtask

    task automatic push_imm(input string n, input ctrl_t c, input logic [15:0] i8, input logic [15:0] i5);
        sb_t e;
        e.name = n; e.exp = c; e.chk_imm = 1'b1; e.imm8 = i8; e.imm5 = i5;
        sbq.push_back(e);
    endtask

    function automatic ctrl_t c_rst();
        ctrl_t c;
        c = '0; c.reset_pc = 1'b1; c.load_pc = 1'b1;
        return c;
    endfunction

    // Issues an instruction on mdata and queues the four fetch/decode cycles
    task automatic fetch(input logic [15:0] instr);
        ctrl_t c;
        $display("%0t issue instruction %h", $time, instr);
        mdata = instr;
        c = '0; c.addr_sel = 1'b1; c.mem_cmd = 2'b01;
        push("IF1", c);
        push("IF2", c);
        c = '0; c.load_pc = 1'b1;
        push("UPDPC", c);
        c = '0;
        push("DECODE", c);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries still pending, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        push_imm("RST", c_rst(), 16'h0000, 16'h0000);
    endtask

    initial begin
        ctrl_t c;
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        mdata   = 16'h0000;
        repeat (2) @(posedge clk);
        release_reset();

        // MOV R1,#5
        fetch(16'hD105);
        c = '0; c.vsel = 2'b10; c.writenum = 3'd1; c.write = 1'b1;
        push_imm("WIMM", c, 16'h0005, 16'h0005);
        drain();

        // ADD R2,R1,R0,LSL#1
        fetch(16'hA148);
        c = '0; c.readnum = 3'd1; c.loada = 1'b1;                 push("ADD_GETA", c);
        c = '0; c.readnum = 3'd0; c.loadb = 1'b1;                 push("ADD_GETB", c);
        c = '0; c.shift = 2'b01; c.loadc = 1'b1;                  push("ADD_ALU", c);
        c = '0; c.writenum = 3'd2; c.write = 1'b1;                push("ADD_WBC", c);
        drain();

        // CMP R1,R0: no write-back cycle at all
        fetch(16'hA900);
        c = '0; c.readnum = 3'd1; c.loada = 1'b1;                 push("CMP_GETA", c);
        c = '0; c.readnum = 3'd0; c.loadb = 1'b1;                 push("CMP_GETB", c);
        c = '0; c.alu_op = 2'b01; c.loads = 1'b1;                 push("CMP_ALU", c);
        drain();

        // LDR R3,[R1,#-1]
        fetch(16'h617F);
        c = '0; c.readnum = 3'd1; c.loada = 1'b1;                 push("LDR_GETA", c);
        c = '0; c.bsel = 1'b1; c.loadc = 1'b1;
        push_imm("LDR_ADDR", c, 16'h007F, 16'hFFFF);
        c = '0; c.load_addr = 1'b1;                               push("LDR_LADDR", c);
        c = '0; c.mem_cmd = 2'b01;                                push("LDR_MRD", c);
        c = '0; c.mem_cmd = 2'b01; c.vsel = 2'b11; c.writenum = 3'd3; c.write = 1'b1;
        push("LDR_MWB", c);
        drain();

        // MOV R1,R0,LSL#1
        fetch(16'hC028);
        c = '0; c.readnum = 3'd0; c.loadb = 1'b1;                 push("MOVR_GETB", c);
        c = '0; c.asel = 1'b1; c.shift = 2'b01; c.loadc = 1'b1;   push("MOVR_ALU", c);
        c = '0; c.writenum = 3'd1; c.write = 1'b1;                push("MOVR_WBC", c);
        drain();

        // STR R3,[R0]
        fetch(16'h8060);
        c = '0; c.readnum = 3'd0; c.loada = 1'b1;                 push("STR_GETA", c);
        c = '0; c.bsel = 1'b1; c.loadc = 1'b1;
        push_imm("STR_ADDR", c, 16'h0060, 16'h0000);
        c = '0; c.load_addr = 1'b1;                               push("STR_LADDR", c);
        c = '0; c.readnum = 3'd3; c.loadb = 1'b1;                 push("STR_SGETB", c);
        c = '0; c.asel = 1'b1; c.loadc = 1'b1;                    push("STR_SMOV", c);
        c = '0; c.mem_cmd = 2'b10;                                push("STR_SWR", c);
        drain();

        // Unknown encoding behaves as a NOP straight back to fetch
        fetch(16'h0000);
        drain();

        // Asynchronous reset while the ADD sits in its ALU cycle
        fetch(16'hA148);
        c = '0; c.readnum = 3'd1; c.loada = 1'b1;                 push("RA_GETA", c);
        c = '0; c.readnum = 3'd0; c.loadb = 1'b1;                 push("RA_GETB", c);
        drain();
        #2;
        c = '0; c.shift = 2'b01; c.loadc = 1'b1;                  push("RA_ALU", c);
        -> probe;
        #1 reset_n = 1'b0;
        #1;
        push_imm("RA_ASYNC_RST", c_rst(), 16'h0000, 16'h0000);
        -> probe;
        #1;
        @(posedge clk);
        release_reset();

        // HALT holds indefinitely
        fetch(16'hE000);
        c = '0; c.halted = 1'b1;
        for (int i = 0; i < 12; i++) push("HALT", c);
        drain();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 mdata  in  16  memory read data, captured into the 16-bit instruction register (IR).
REQ-005 readnum  out  3  regfile read index.
REQ-006 writenum  out  3  regfile write index.
REQ-007 vsel  out  2  write-back select: 00 C, 01 PC, 10 sximm8, 11 mdata.
REQ-008 write  out  1  regfile write enable.
REQ-009 loada  out  1  A register enable.
REQ-010 loadb  out  1  B register enable.
REQ-011 loadc  out  1  C register enable.
REQ-012 loads  out  1  status register enable.
REQ-013 asel  out  1  1 forces ALU A operand to 0.
REQ-014 bsel  out  1  1 selects sximm5 as ALU B operand.
REQ-015 muxccontrol  out  1  A/B load-source select; constant 0.
REQ-016 shift  out  2  shifter op.
REQ-017 ALUop  out  2  ALU op.
REQ-018 sximm8  out  16  IR[7:0] sign-extended.
REQ-019 sximm5  out  16  IR[4:0] sign-extended.
REQ-020 mem_cmd  out  2  00 none, 01 read, 10 write.
REQ-021 addr_sel  out  1  1 selects PC as memory address; 0 selects the data-address register.
REQ-022 load_pc  out  1  PC register enable.
REQ-023 reset_pc  out  1  when 1, the PC loads 0 instead of PC+1.
REQ-024 load_addr  out  1  data-address register enable; loads from C.
REQ-025 halted  out  1  1 while in HALT.

Function
REQ-026 IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
REQ-027 Outputs are Moore, decoded from the current state and the IR; every output not listed for a state is 0.
REQ-028 Fetch states:
- RST: reset_pc=1, load_pc=1 -> IF1.
- IF1: addr_sel=1, mem_cmd=01 -> IF2.
- IF2: addr_sel=1, mem_cmd=01; IR loads mdata at the end of the cycle -> UPDPC.
- UPDPC: load_pc=1 -> DECODE.
REQ-029 DECODE dispatch:
- 11010 (MOV imm): -> WIMM.
- 11000 (MOV reg) or 10111 (MVN): -> GETB.
- 10100 (ADD), 10101 (CMP), 10110 (AND): -> GETA.
- 01100 (LDR) or 10000 (STR): -> GETA.
- 11100: -> HALT.
- Any other encoding: NOP -> IF1.
REQ-030 WIMM: vsel=10, writenum=Rn, write=1 -> IF1.
REQ-031 GETA: readnum=Rn, loada=1 -> GETB for ALU class; -> ADDR for LDR/STR.
REQ-032 GETB: readnum=Rm, loadb=1 -> ALU.
REQ-033 ALU state:
- shift=sh; ALUop=op, except MOV reg uses ALUop=00.
- asel=1 for MOV reg.
- CMP: loads=1, loadc=0 -> IF1.
- All others: loadc=1 -> WBC.
REQ-034 WBC: vsel=00, writenum=Rd, write=1 -> IF1.
REQ-035 ADDR: bsel=1, ALUop=00, loadc=1 -> LADDR.
REQ-036 LADDR: load_addr=1 -> MRD for LDR; -> SGETB for STR.
REQ-037 LDR read: MRD: addr_sel=0, mem_cmd=01 -> MWB. MWB: mem_cmd=01, vsel=11, writenum=Rd, write=1 -> IF1.
REQ-038 STR write:
- SGETB: readnum=Rd, loadb=1 -> SMOV.
- SMOV: asel=1, shift=00, ALUop=00, loadc=1 -> SWR.
- SWR: addr_sel=0, mem_cmd=10 -> IF1.
REQ-039 HALT: halted=1, mem_cmd=00; holds until reset.
REQ-040 sximm8 and sximm5 are driven continuously from the IR.

Reset
REQ-041 reset_n low forces state=RST and IR=0x0000 immediately, independent of clk, from any state including mid-instruction; in RST the outputs are reset_pc=1, load_pc=1, all others 0.
REQ-042 The first rising edge after reset_n rises leaves RST -> IF1.

Verification
REQ-043 Assert reset_n low while in ALU -> state RST and write=loadc=0 without a clock edge; after release: RST, IF1 (mem_cmd=01, addr_sel=1).
REQ-044 Fetch 0xD105 (MOV R1,#5) -> IF1, IF2, UPDPC, DECODE, WIMM, then IF1; WIMM drives vsel=10, writenum=1, write=1, sximm8=0x0005.
REQ-045 Fetch 0xA148 (ADD R2,R1,R0,LSL#1) -> sequence:
- GETA: readnum=1, loada=1.
- GETB: readnum=0, loadb=1.
- ALU: shift=01, ALUop=00, loadc=1.
- WBC: writenum=2, write=1.
REQ-046 Fetch 0xA900 (CMP R1,R0) -> ALU state drives ALUop=01, loads=1, loadc=0; write stays 0 for the whole instruction.
REQ-047 Fetch 0x617F (LDR R3,[R1,#-1]) -> sequence:
- ADDR: sximm5=0xFFFF, bsel=1.
- LADDR: load_addr=1.
- MRD: addr_sel=0, mem_cmd=01.
- MWB: vsel=11, writenum=3, write=1.
REQ-048 Fetch 0xE000 -> HALT with halted=1 and mem_cmd=00 for 10+ cycles; 0x8060 (STR R3,[R0]) -> SWR drives mem_cmd=10, addr_sel=0.
